barrel_shifter_pipe: RTL and testbench



---
 rtl/barrel_shifter_pipe_if.sv | 31 +++
 rtl/barrel_shifter_pipe.sv | 112 +++++++++++
 tb/tb_barrel_shifter_pipe.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/barrel_shifter_pipe_if.sv
// Request/result handshake bundle for barrel_shifter_pipe.
// in_*: operand, amount, direction and op with valid/ready; out_*: result with valid/ready plus zero/err flags.
// master = surrounding environment (drives requests, accepts results); slave = the shifter.
interface barrel_shifter_pipe_if #(
  parameter int WIDTH = 32
);
  localparam int AW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AW-1:0]    in_amt;
  logic             in_dir;    // 1 = left, 0 = right
  logic [1:0]       in_op;     // 00 rotate, 01 logical, 10 arithmetic, 11 reserved

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             out_err;

  modport master (
    output in_valid, in_data, in_amt, in_dir, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_err
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_dir, in_op, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_err
  );
endinterface

// File: rtl/barrel_shifter_pipe.sv
// Pipelined rotate / logical / arithmetic barrel shifter, one register stage per amount bit.
// Latency AW = log2(WIDTH) cycles, one operation per clock; all stages stall together when the result is held.
// Ports: clk, reset (sync, active-high), bus (slave modport: in_* request, out_* result, out_zero, out_err).
module barrel_shifter_pipe #(
  parameter int WIDTH = 32
) (
  input logic                  clk,
  input logic                  reset,
  barrel_shifter_pipe_if.slave bus
);
  localparam int AW = $clog2(WIDTH);

  logic en;

  // Stage boundary signals: index 0 is the input port, index k+1 is the output of stage k.
  logic             s_vld [AW+1];
  logic [WIDTH-1:0] s_dat [AW+1];
  logic             s_err [AW+1];
  // Control only needed by later stages; the last stage does not register it.
  logic [AW-1:0]    s_amt [AW];   // remaining amount, bit 0 is the one stage k consumes
  logic             s_dir [AW];
  logic             s_sgn [AW];   // original operand MSB, fill for arithmetic right
  logic [1:0]       s_op  [AW];

  // Global enable: everything advances unless a result is being held.
  assign en           = !s_vld[AW] || bus.out_ready;
  assign bus.in_ready = en;

  assign s_vld[0] = bus.in_valid;
  assign s_dat[0] = bus.in_data;
  assign s_err[0] = (bus.in_op == 2'b11);
  assign s_amt[0] = bus.in_amt;
  assign s_dir[0] = bus.in_dir;
  assign s_sgn[0] = bus.in_data[WIDTH-1];
  assign s_op[0]  = bus.in_op;

  for (genvar k = 0; k < AW; k++) begin : g_stage
    localparam int N = 1 << k;

    logic             vld_q;
    logic             err_q;
    logic [WIDTH-1:0] dat_q;
    logic [WIDTH-1:0] dat_d;

    always_comb begin
      dat_d = s_dat[k];
      if (s_amt[k][0]) begin
        unique case (s_op[k])
          2'b00:   dat_d = s_dir[k] ? {s_dat[k][WIDTH-1-N:0], s_dat[k][WIDTH-1:WIDTH-N]}
                                    : {s_dat[k][N-1:0], s_dat[k][WIDTH-1:N]};
          2'b01:   dat_d = s_dir[k] ? {s_dat[k][WIDTH-1-N:0], {N{1'b0}}}
                                    : {{N{1'b0}}, s_dat[k][WIDTH-1:N]};
          2'b10:   dat_d = s_dir[k] ? {s_dat[k][WIDTH-1-N:0], {N{1'b0}}}
                                    : {{N{s_sgn[k]}}, s_dat[k][WIDTH-1:N]};
          default: dat_d = s_dat[k];  // reserved op passes data through
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        vld_q <= 1'b0;
        err_q <= 1'b0;
        dat_q <= '0;
      end else if (en) begin
        vld_q <= s_vld[k];
        err_q <= s_err[k];
        dat_q <= dat_d;
      end
    end

    assign s_vld[k+1] = vld_q;
    assign s_err[k+1] = err_q;
    assign s_dat[k+1] = dat_q;

    if (k < AW-1) begin : g_ctl
      logic [AW-1:0] amt_q;
      logic          dir_q;
      logic          sgn_q;
      logic [1:0]    op_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          amt_q <= '0;
          dir_q <= 1'b0;
          sgn_q <= 1'b0;
          op_q  <= 2'b00;
        end else if (en) begin
          amt_q <= s_amt[k] >> 1;  // next stage sees its own bit at position 0
          dir_q <= s_dir[k];
          sgn_q <= s_sgn[k];
          op_q  <= s_op[k];
        end
      end

      assign s_amt[k+1] = amt_q;
      assign s_dir[k+1] = dir_q;
      assign s_sgn[k+1] = sgn_q;
      assign s_op[k+1]  = op_q;
    end
  end

  // The last stage only consumes bit 0 of its remaining amount.
  logic unused_amt_hi;
  assign unused_amt_hi = ^s_amt[AW-1][AW-1:1];

  assign bus.out_valid = s_vld[AW];
  assign bus.out_data  = s_dat[AW];
  assign bus.out_err   = s_err[AW];
  // Qualified by valid so an empty (reset) pipeline does not report a zero result.
  assign bus.out_zero  = s_vld[AW] && (s_dat[AW] == '0);
endmodule

// File: tb/tb_barrel_shifter_pipe.sv
module tb_barrel_shifter_pipe;
  localparam int W  = 32;
  localparam int AW = 5;

  typedef struct {
    logic [W-1:0] d;
    logic         z;
    logic         e;
    int           c;
  } exp_t;

  typedef struct {
    logic [W-1:0] ad;
    logic         az;
    logic         ae;
    logic [W-1:0] ed;
    logic         ez;
    logic         ee;
    int           lat;
    bit           spur;
  } res_t;

  logic clk = 1'b0;
  logic reset;

  barrel_shifter_pipe_if #(.WIDTH(W)) bus ();
  barrel_shifter_pipe #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  exp_t sb[$];
  res_t res_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   acc;

  // Reference: whole-word operation computed directly from the amount.
  function automatic logic [W-1:0] ref_op(input logic [W-1:0] d, input int a,
                                          input logic dir, input logic [1:0] op);
    logic signed [W-1:0] s;
    logic [W-1:0] r;
    r = d;
    if (op == 2'b00 && dir)       r = (d << a) | (d >> (W - a));
    else if (op == 2'b00)         r = (d >> a) | (d << (W - a));
    else if (op != 2'b11 && dir)  r = d << a;
    else if (op == 2'b01)         r = d >> a;
    else if (op == 2'b10) begin
      s = d;
      s = s >>> a;
      r = s;
    end
    return r;
  endfunction

  // One clock: record handshakes at the falling edge, return at rising edge + 1.
  task automatic tick();
    exp_t e;
    res_t r;
    @(negedge clk);
    acc = 1'b0;
    if (reset) begin
      sb.delete();
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        acc = 1'b1;
        e.d = ref_op(bus.in_data, int'(bus.in_amt), bus.in_dir, bus.in_op);
        e.z = (e.d == '0);
        e.e = (bus.in_op == 2'b11);
        e.c = cyc;
        sb.push_back(e);
      end
      if (bus.out_valid && bus.out_ready) begin
        r.ad = bus.out_data;
        r.az = bus.out_zero;
        r.ae = bus.out_err;
        r.spur = (sb.size() == 0);
        if (!r.spur) begin
          e = sb.pop_front();
          r.ed = e.d; r.ez = e.z; r.ee = e.e; r.lat = cyc - e.c;
        end else begin
          r.ed = 'x; r.ez = 1'bx; r.ee = 1'bx; r.lat = -1;
        end
        res_q.push_back(r);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic issue(input logic [W-1:0] d, input int a, input logic dir, input logic [1:0] op);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_amt   = a[AW-1:0];
    bus.in_dir   = dir;
    bus.in_op    = op;
    do begin
      tick();
      n++;
    end while (!acc && n < 50);
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL issue_accept got=not_accepted want=accepted_within_50");
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;  // must not be taken while reset is high
    bus.in_data   = 32'h1234_5678;
    bus.in_amt    = 5'd3;
    bus.in_dir    = 1'b0;
    bus.in_op     = 2'b00;
    tick();
    tick();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b want=0", bus.out_valid); end
    checks++; if (bus.out_data !== 32'h0) begin failures++; $display("FAIL rst_out_data got=%h want=0", bus.out_data); end
    checks++; if (bus.out_zero !== 1'b0) begin failures++; $display("FAIL rst_out_zero got=%b want=0", bus.out_zero); end
    checks++; if (bus.out_err !== 1'b0) begin failures++; $display("FAIL rst_out_err got=%b want=0", bus.out_err); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b want=1", bus.in_ready); end
    idle(AW + 3);
    checks++; if (res_q.size() != 0) begin failures++; $display("FAIL rst_in_valid_taken got=%0d results want=0", res_q.size()); end
  endtask

  task automatic test_rotate();
    logic [W-1:0] din [3] = '{32'h8000_0001, 32'h1234_5678, 32'h0000_FFFF};
    int           amt [3] = '{1, 4, 16};
    logic         dir [3] = '{1'b0, 1'b1, 1'b0};
    logic [W-1:0] want[3] = '{32'hC000_0000, 32'h2345_6781, 32'hFFFF_0000};
    res_t r;
    res_q.delete();
    for (int i = 0; i < 3; i++) issue(din[i], amt[i], dir[i], 2'b00);
    idle(AW + 3);
    checks++;
    if (res_q.size() != 3) begin
      failures++; $display("FAIL rot_count got=%0d want=3", res_q.size()); return;
    end
    for (int i = 0; i < 3; i++) begin
      r = res_q.pop_front();
      checks++;
      if (r.spur || r.ad !== want[i] || r.az !== 1'b0 || r.ae !== 1'b0 || r.lat !== AW) begin
        failures++;
        $display("FAIL rot_%0d got=%h z=%b e=%b lat=%0d want=%h z=0 e=0 lat=%0d", i, r.ad, r.az, r.ae, r.lat, want[i], AW);
      end
    end
  endtask

  task automatic test_shifts();
    logic [W-1:0] din [4] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001};
    int           amt [4] = '{31, 31, 31, 1};
    logic         dir [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [1:0]   op  [4] = '{2'b10, 2'b01, 2'b01, 2'b01};
    logic [W-1:0] want[4] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000};
    logic         wz  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    res_t r;
    res_q.delete();
    for (int i = 0; i < 4; i++) issue(din[i], amt[i], dir[i], op[i]);
    idle(AW + 3);
    checks++;
    if (res_q.size() != 4) begin
      failures++; $display("FAIL shift_count got=%0d want=4", res_q.size()); return;
    end
    for (int i = 0; i < 4; i++) begin
      r = res_q.pop_front();
      checks++;
      if (r.spur || r.ad !== want[i] || r.az !== wz[i] || r.ae !== 1'b0 || r.lat !== AW) begin
        failures++;
        $display("FAIL shift_%0d got=%h z=%b e=%b lat=%0d want=%h z=%b e=0 lat=%0d", i, r.ad, r.az, r.ae, r.lat, want[i], wz[i], AW);
      end
    end
  endtask

  task automatic test_sweep();
    logic [W-1:0] din[$];
    int           amt_l[$];
    logic [W-1:0] d;
    res_t r;
    res_q.delete();
    for (int a = 0; a < W; a++)
      for (int dr = 0; dr < 2; dr++)
        for (int op = 0; op < 3; op++) begin
          d = $urandom();
          din.push_back(d);
          amt_l.push_back(a);
          issue(d, a, dr[0], op[1:0]);
        end
    idle(AW + 3);
    checks++;
    if (res_q.size() != din.size()) begin
      failures++; $display("FAIL sweep_count got=%0d want=%0d", res_q.size(), din.size()); return;
    end
    for (int i = 0; i < din.size(); i++) begin
      r = res_q.pop_front();
      checks++;
      if (r.spur || r.ad !== r.ed || r.az !== r.ez || r.ae !== 1'b0 || r.lat !== AW) begin
        failures++;
        $display("FAIL sweep_%0d got=%h z=%b e=%b lat=%0d want=%h z=%b e=0 lat=%0d", i, r.ad, r.az, r.ae, r.lat, r.ed, r.ez, AW);
      end
      if (amt_l[i] == 0) begin
        checks++;
        if (r.ad !== din[i]) begin
          failures++; $display("FAIL sweep_amt0_%0d got=%h want=%h", i, r.ad, din[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure(input bit bubbles);
    logic [W-1:0] sd[8];
    int           sa[8];
    logic         sdir[8];
    logic [1:0]   sop[8];
    logic [W-1:0] hd;
    logic         hz, he, hold;
    int sent = 0;
    int i = 0;
    res_t r;
    for (int k = 0; k < 8; k++) begin
      sd[k] = $urandom(); sa[k] = $urandom_range(0, W-1);
      sdir[k] = $urandom_range(0, 1); sop[k] = 2'($urandom_range(0, 2));
    end
    res_q.delete();
    while ((sent < 8 || sb.size() != 0) && i < 100) begin
      bus.in_valid = (sent < 8) && (!bubbles || (i % 2 == 0));
      if (sent < 8) begin
        bus.in_data = sd[sent]; bus.in_amt = sa[sent][AW-1:0];
        bus.in_dir = sdir[sent]; bus.in_op = sop[sent];
      end
      bus.out_ready = !(i >= 7 && i < 10);
      #1;
      hold = bus.out_valid && !bus.out_ready;
      hd = bus.out_data; hz = bus.out_zero; he = bus.out_err;
      if (hold) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin
          failures++; $display("FAIL bp%0d_in_ready cyc=%0d got=%b want=0", bubbles, i, bus.in_ready);
        end
      end
      tick();
      if (acc) sent++;
      if (hold) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== hd || bus.out_zero !== hz || bus.out_err !== he) begin
          failures++;
          $display("FAIL bp%0d_stable cyc=%0d got=%b/%h/%b/%b want=1/%h/%b/%b", bubbles, i,
                   bus.out_valid, bus.out_data, bus.out_zero, bus.out_err, hd, hz, he);
        end
      end
      i++;
    end
    bus.out_ready = 1'b1;
    checks++;
    if (i >= 100) begin failures++; $display("FAIL bp%0d_timeout got=sent_%0d want=8_drained", bubbles, sent); end
    idle(4);
    checks++;
    if (res_q.size() != 8) begin
      failures++; $display("FAIL bp%0d_count got=%0d want=8", bubbles, res_q.size()); return;
    end
    for (int k = 0; k < 8; k++) begin
      r = res_q.pop_front();
      checks++;
      if (r.spur || r.ad !== ref_op(sd[k], sa[k], sdir[k], sop[k]) || r.az !== r.ez || r.ae !== 1'b0) begin
        failures++;
        $display("FAIL bp%0d_res_%0d got=%h z=%b e=%b want=%h z=%b e=0", bubbles, k, r.ad, r.az, r.ae,
                 ref_op(sd[k], sa[k], sdir[k], sop[k]), r.ez);
      end
    end
  endtask

  task automatic test_reserved();
    logic [W-1:0] d2;
    res_t r;
    d2 = $urandom();
    res_q.delete();
    issue(32'hDEAD_BEEF, 7, 1'b0, 2'b11);
    issue(d2, 3, 1'b1, 2'b00);
    idle(AW + 3);
    checks++;
    if (res_q.size() != 2) begin
      failures++; $display("FAIL rsv_count got=%0d want=2", res_q.size()); return;
    end
    r = res_q.pop_front();
    checks++;
    if (r.spur || r.ad !== 32'hDEAD_BEEF || r.ae !== 1'b1 || r.lat !== AW) begin
      failures++; $display("FAIL rsv_op11 got=%h e=%b lat=%0d want=deadbeef e=1 lat=%0d", r.ad, r.ae, r.lat, AW);
    end
    r = res_q.pop_front();
    checks++;
    if (r.spur || r.ad !== {d2[28:0], d2[31:29]} || r.ae !== 1'b0) begin
      failures++; $display("FAIL rsv_next got=%h e=%b want=%h e=0", r.ad, r.ae, {d2[28:0], d2[31:29]});
    end
  endtask

  task automatic test_reset_mid();
    res_t r;
    res_q.delete();
    for (int k = 0; k < 3; k++) issue($urandom() | 32'h1, k + 1, 1'b1, 2'b00);
    reset = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid got=%b want=0", bus.out_valid); end
    checks++; if (bus.out_data !== 32'h0) begin failures++; $display("FAIL mid_out_data got=%h want=0", bus.out_data); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready got=%b want=1", bus.in_ready); end
    idle(AW + 5);
    checks++; if (res_q.size() != 0) begin failures++; $display("FAIL mid_stale got=%0d results want=0", res_q.size()); end
    issue(32'h0000_00F0, 4, 1'b0, 2'b01);
    idle(AW + 3);
    checks++;
    if (res_q.size() != 1) begin
      failures++; $display("FAIL mid_new_count got=%0d want=1", res_q.size()); return;
    end
    r = res_q.pop_front();
    checks++;
    if (r.spur || r.ad !== 32'h0000_000F || r.lat !== AW) begin
      failures++; $display("FAIL mid_new got=%h lat=%0d want=0000000f lat=%0d", r.ad, r.lat, AW);
    end
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_shifts();
    test_sweep();
    test_backpressure(1'b0);
    test_backpressure(1'b1);
    test_reserved();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
